qpsk_demodulator: RTL

- Receive-side counterpart of the QPSK modulator. Consumes the modulator's 9-bit carrier sample stream and recovers one I bit and one Q bit per symbol.
- Each symbol's samples are correlated against internal cosine (I) and sine (Q) reference tables. The sign of each correlation gives the bit.
- Sits after the modulator on the same sample clock and drives I_demodulate / Q_demodulate at top level.

---
 rtl/qpsk_demodulator.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/qpsk_demodulator.sv
// ---------------------------------------------------------------------------
// qpsk_demodulator
//
// Purpose:
//   Recovers one I bit and one Q bit per symbol from the QPSK modulator's
//   offset-binary carrier samples. Each symbol (SPS samples, one carrier
//   period) is correlated against built-in cosine and sine tables, and the
//   sign of each correlation is the decided bit (zero decides as 1).
//
// Ports:
//   clk           sample clock, rising edge
//   rst_n         asynchronous active-low reset
//   QPSK_out      modulated sample, unsigned offset-binary (midscale 256)
//   sample_valid  QPSK_out is valid this cycle
//   sym_sync      QPSK_out is phase 0 of a symbol (qualified by sample_valid)
//   I_demodulate  recovered in-phase bit, held until the next decision
//   Q_demodulate  recovered quadrature bit, held until the next decision
//   bit_valid     one-cycle pulse when a new I/Q decision is presented
//   locked        high once symbol alignment has been established
//   sync_err      one-cycle pulse when sym_sync arrives mid-symbol
// ---------------------------------------------------------------------------
module qpsk_demodulator #(
  parameter int SAMPLE_W = 9,
  parameter int SPS      = 16,
  parameter int REF_W    = 8,
  parameter int ACC_W    = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] QPSK_out,
  input  logic                sample_valid,
  input  logic                sym_sync,
  output logic                I_demodulate,
  output logic                Q_demodulate,
  output logic                bit_valid,
  output logic                locked,
  output logic                sync_err
);

  localparam int PH_W   = $clog2(SPS);
  localparam int PROD_W = SAMPLE_W + REF_W;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(SPS - 1);

  // Elaboration-time table generator. cos(x) by Taylor series in Q28 fixed
  // point over x in [-pi, pi]; sin(x) is taken as cos(x - pi/2). The result
  // is scaled by 2^(REF_W-1)-1 and rounded half away from zero.
  function automatic logic signed [REF_W-1:0] ref_val(input int k, input bit is_sin);
    longint pi_q;
    longint ang;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    longint r;
    pi_q = 64'sd843314857;
    ang  = (2 * pi_q * longint'(k)) / longint'(SPS);
    if (is_sin) ang = ang - pi_q / 2;
    if (ang > pi_q)  ang = ang - 2 * pi_q;
    if (ang < -pi_q) ang = ang + 2 * pi_q;
    x2   = (ang * ang) >>> 28;
    term = longint'(1) <<< 28;
    sum  = term;
    for (int n = 1; n <= 20; n++) begin
      term = -((term * x2) >>> 28) / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    amp = longint'((1 << (REF_W - 1)) - 1);
    if (sum >= 0) r = (amp * sum + (longint'(1) <<< 27)) >>> 28;
    else          r = -((amp * (-sum) + (longint'(1) <<< 27)) >>> 28);
    return r[REF_W-1:0];
  endfunction

  logic signed [REF_W-1:0] cos_tbl [SPS];
  logic signed [REF_W-1:0] sin_tbl [SPS];

  for (genvar gi = 0; gi < SPS; gi++) begin : g_tbl
    assign cos_tbl[gi] = ref_val(gi, 1'b0);
    assign sin_tbl[gi] = ref_val(gi, 1'b1);
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                     state_q,    state_d;
  logic [PH_W-1:0]            phase_q,    phase_d;
  logic                       locked_q,   locked_d;
  logic                       sync_err_q, sync_err_d;
  // stage 1: products plus flags
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_first_q, s1_first_d;
  logic                       s1_last_q,  s1_last_d;
  logic signed [PROD_W-1:0]   p_i_q,      p_i_d;
  logic signed [PROD_W-1:0]   p_q_q,      p_q_d;
  // stage 2: accumulators
  logic signed [ACC_W-1:0]    acc_i_q,    acc_i_d;
  logic signed [ACC_W-1:0]    acc_q_q,    acc_q_d;
  logic                       s2_last_q,  s2_last_d;
  // decision and output registers
  logic                       dec_valid_q, dec_valid_d;
  logic                       dec_i_q,     dec_i_d;
  logic                       dec_q_q,     dec_q_d;
  logic                       out_i_q,     out_i_d;
  logic                       out_q_q,     out_q_d;
  logic                       out_bv_q,    out_bv_d;

  logic                       take;
  logic [PH_W-1:0]            cur_phase;
  logic signed [SAMPLE_W-1:0] s_c;

  // Subtracting midscale from offset-binary is just an MSB flip.
  assign s_c = {~QPSK_out[SAMPLE_W-1], QPSK_out[SAMPLE_W-2:0]};

  // Alignment control: decides whether this sample is processed and at
  // which phase. A mid-symbol sym_sync restarts at phase 0; the phase-0
  // load in stage 2 then overwrites whatever the aborted symbol had summed.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    locked_d   = locked_q;
    sync_err_d = 1'b0;
    take       = 1'b0;
    cur_phase  = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_valid && sym_sync) begin
          take      = 1'b1;
          cur_phase = '0;
          state_d   = ST_RUN;
          locked_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (sample_valid) begin
          take = 1'b1;
          if (sym_sync && (phase_q != '0)) begin
            cur_phase  = '0;
            sync_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // SPS is a power of two, so the phase counter wraps on its own.
    if (take) phase_d = cur_phase + 1'b1;
  end

  // Stage 1: multiply by the reference at the current phase.
  always_comb begin
    s1_valid_d = take;
    s1_first_d = take && (cur_phase == '0);
    s1_last_d  = take && (cur_phase == LAST_PH);
    p_i_d      = p_i_q;
    p_q_d      = p_q_q;
    if (take) begin
      p_i_d = PROD_W'(s_c) * PROD_W'(cos_tbl[cur_phase]);
      p_q_d = PROD_W'(s_c) * PROD_W'(sin_tbl[cur_phase]);
    end
  end

  // Stage 2: phase-0 products load, later products add.
  always_comb begin
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    s2_last_d = s1_valid_q && s1_last_q;
    if (s1_valid_q) begin
      if (s1_first_q) begin
        acc_i_d = ACC_W'(p_i_q);
        acc_q_d = ACC_W'(p_q_q);
      end else begin
        acc_i_d = acc_i_q + ACC_W'(p_i_q);
        acc_q_d = acc_q_q + ACC_W'(p_q_q);
      end
    end
  end

  // Sign decision, then a presentation register so the pulse lands three
  // edges after the edge that took the final sample.
  always_comb begin
    dec_valid_d = s2_last_q;
    dec_i_d     = dec_i_q;
    dec_q_d     = dec_q_q;
    if (s2_last_q) begin
      dec_i_d = ~acc_i_q[ACC_W-1];
      dec_q_d = ~acc_q_q[ACC_W-1];
    end
    out_bv_d = dec_valid_q;
    out_i_d  = dec_valid_q ? dec_i_q : out_i_q;
    out_q_d  = dec_valid_q ? dec_q_q : out_q_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      p_i_q       <= '0;
      p_q_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      s2_last_q   <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_i_q     <= 1'b0;
      dec_q_q     <= 1'b0;
      out_i_q     <= 1'b0;
      out_q_q     <= 1'b0;
      out_bv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      p_i_q       <= p_i_d;
      p_q_q       <= p_q_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      s2_last_q   <= s2_last_d;
      dec_valid_q <= dec_valid_d;
      dec_i_q     <= dec_i_d;
      dec_q_q     <= dec_q_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_bv_q    <= out_bv_d;
    end
  end

  assign I_demodulate = out_i_q;
  assign Q_demodulate = out_q_q;
  assign bit_valid    = out_bv_q;
  assign locked       = locked_q;
  assign sync_err     = sync_err_q;

endmodule
